mux_n_pipe: RTL and testbench

MUX_N_PIPE -- requirements
Module: mux_n_pipe

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_skid_stage.sv | 69 ++++++
 rtl/mux_n_pipe.sv | 69 ++++++
 tb/tb_mux_n_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined N:1 multiplexer.
package mux_pkg;

  localparam int DEF_SIZE = 32;
  localparam int DEF_NUM  = 4;
  localparam int MAX_NUM  = 16;

  // Ceiling log2, used only on elaboration-time constants to size the select.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_skid_stage.sv
// Two-entry output stage (main register + skid register) with valid/ready on
// both sides. The payload is opaque: the top packs data plus an optional
// select-error bit into WIDTH.
//
// Handshake: a word moves on a side only in a cycle where that side's valid
// and ready are both 1; valid must not depend on ready. ready_o is a flop
// (NOT skid_valid), so ready_i never reaches ready_o combinationally.
module mux_skid_stage #(
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             r_main_valid;
  logic [WIDTH-1:0] r_main_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_ready;

  logic w_accept;
  logic w_main_free;

  assign w_accept    = valid_i && r_ready;
  // Main can take a new word if it is empty or being drained this cycle.
  assign w_main_free = !r_main_valid || ready_i;

  // Main/skid update: skid refills main first; otherwise new words go to main
  // when it is free and to skid when main is stalled.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_ready      <= 1'b1;
    end else if (r_skid_valid) begin
      // Skid full implies main full and ready_o low: no accept possible here.
      if (ready_i) begin
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
        r_skid_data  <= '0;
        r_ready      <= 1'b1;
      end
    end else if (w_accept) begin
      if (w_main_free) begin
        r_main_data  <= data_i;
        r_main_valid <= 1'b1;
      end else begin
        r_skid_data  <= data_i;
        r_skid_valid <= 1'b1;
        r_ready      <= 1'b0;
      end
    end else if (ready_i) begin
      r_main_valid <= 1'b0;
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_main_valid;
  assign data_o  = r_main_data;

endmodule

// File: rtl/mux_n_pipe.sv
// Pipelined N:1 multiplexer with a valid/ready skid output stage.
// Optional feature macro: MUX_N_PIPE_SEL_CHECK_EN -- when defined, each word
// carries a flag telling whether its select was out of range (>= NUM);
// when undefined, sel_err_o is tied 0 and no flag storage exists.
// An out-of-range select always forwards input 0.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int NUM   = DEF_NUM,
  parameter int SEL_W = clog2(NUM)
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [NUM*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]    select_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [SIZE-1:0]     data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                sel_err_o
);

  logic [SIZE-1:0] w_sel_data;

  // Select the addressed input; anything not matching 0..NUM-1 falls back to input 0.
  always_comb begin
    w_sel_data = data_i[0 +: SIZE];
    for (int k = 1; k < NUM; k++) begin
      if (select_i == SEL_W'(k)) w_sel_data = data_i[k*SIZE +: SIZE];
    end
  end

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  localparam int ST_W = SIZE + 1;
  logic            w_sel_err;
  logic [ST_W-1:0] w_stage_in;
  logic [ST_W-1:0] w_stage_out;

  // Widen by one bit so NUM=16 (select can never exceed) still compares cleanly.
  assign w_sel_err  = ({1'b0, select_i} > (SEL_W+1)'(NUM - 1));
  assign w_stage_in = {w_sel_err, w_sel_data};
  assign data_o     = w_stage_out[SIZE-1:0];
  assign sel_err_o  = w_stage_out[SIZE];
`else
  localparam int ST_W = SIZE;
  logic [ST_W-1:0] w_stage_in;
  logic [ST_W-1:0] w_stage_out;

  assign w_stage_in = w_sel_data;
  assign data_o     = w_stage_out;
  assign sel_err_o  = 1'b0;
`endif

  mux_skid_stage #(
    .WIDTH(ST_W)
  ) u_stage (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (w_stage_in),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (w_stage_out)
  );

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: default (4x32), 3x8 and 16x8 instances.
module tb_mux_n_pipe;

  logic clk;
  logic rst_n;

  // Default instance: NUM=4, SIZE=32
  logic [127:0] d4_data;
  logic [1:0]   d4_sel;
  logic         d4_valid, d4_ready_i;
  logic         d4_ready_o, d4_valid_o, d4_err;
  logic [31:0]  d4_out;

  // NUM=3, SIZE=8
  logic [23:0]  d3_data;
  logic [1:0]   d3_sel;
  logic         d3_valid, d3_ready_i;
  logic         d3_ready_o, d3_valid_o, d3_err;
  logic [7:0]   d3_out;

  // NUM=16, SIZE=8
  logic [127:0] d16_data;
  logic [3:0]   d16_sel;
  logic         d16_valid, d16_ready_i;
  logic         d16_ready_o, d16_valid_o, d16_err;
  logic [7:0]   d16_out;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  mux_n_pipe u_dut (
    .clk_i(clk), .rst_n(rst_n), .data_i(d4_data), .select_i(d4_sel),
    .valid_i(d4_valid), .ready_o(d4_ready_o), .data_o(d4_out),
    .valid_o(d4_valid_o), .ready_i(d4_ready_i), .sel_err_o(d4_err)
  );

  mux_n_pipe #(.SIZE(8), .NUM(3), .SEL_W(2)) u_dut3 (
    .clk_i(clk), .rst_n(rst_n), .data_i(d3_data), .select_i(d3_sel),
    .valid_i(d3_valid), .ready_o(d3_ready_o), .data_o(d3_out),
    .valid_o(d3_valid_o), .ready_i(d3_ready_i), .sel_err_o(d3_err)
  );

  mux_n_pipe #(.SIZE(8), .NUM(16), .SEL_W(4)) u_dut16 (
    .clk_i(clk), .rst_n(rst_n), .data_i(d16_data), .select_i(d16_sel),
    .valid_i(d16_valid), .ready_o(d16_ready_o), .data_o(d16_out),
    .valid_o(d16_valid_o), .ready_i(d16_ready_i), .sel_err_o(d16_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle: inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d4_data = '0;  d4_sel = '0;  d4_valid = 1'b0;  d4_ready_i = 1'b1;
    d3_data = '0;  d3_sel = '0;  d3_valid = 1'b0;  d3_ready_i = 1'b1;
    d16_data = '0; d16_sel = '0; d16_valid = 1'b0; d16_ready_i = 1'b1;
    #12;
    n_checks++;
    if (d4_valid_o !== 1'b0 || d4_ready_o !== 1'b1 || d4_out !== 32'h0 || d4_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b data=%h err=%b, want 0 1 0 0",
               d4_valid_o, d4_ready_o, d4_out, d4_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Select 2 then 0 on consecutive cycles, ready held high.
  task automatic test_select();
    d4_data    = {32'h44, 32'h33, 32'h22, 32'h11};
    d4_ready_i = 1'b1;
    d4_valid   = 1'b1;
    d4_sel     = 2'd2;
    tick();
    d4_sel = 2'd0;
    n_checks++;
    if (d4_valid_o !== 1'b1 || d4_out !== 32'h33) begin
      n_fail++;
      $display("FAIL select_2: valid=%b data=%h, want 1 00000033", d4_valid_o, d4_out);
    end
    tick();
    d4_valid = 1'b0;
    n_checks++;
    if (d4_valid_o !== 1'b1 || d4_out !== 32'h11) begin
      n_fail++;
      $display("FAIL select_0: valid=%b data=%h, want 1 00000011", d4_valid_o, d4_out);
    end
    tick();
    n_checks++;
    if (d4_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL select_drain: valid=%b, want 0", d4_valid_o);
    end
  endtask

  // Out-of-range select on a 3-input mux forwards input 0.
  task automatic test_sel_err();
    d3_data  = {8'hCC, 8'hBB, 8'hAA};
    d3_valid = 1'b1;
    d3_sel   = 2'd3;
    tick();
    d3_sel = 2'd1;
    n_checks++;
    if (d3_out !== 8'hAA || d3_err !== EXP_ERR || d3_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sel_out_of_range: data=%h err=%b valid=%b, want aa %b 1",
               d3_out, d3_err, d3_valid_o, EXP_ERR);
    end
    tick();
    d3_valid = 1'b0;
    n_checks++;
    if (d3_out !== 8'hBB || d3_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_in_range: data=%h err=%b, want bb 0", d3_out, d3_err);
    end
    tick();
  endtask

  // Stall: A in main, B in skid, C refused; then drain in order.
  task automatic test_stall();
    d4_data    = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    d4_ready_i = 1'b0;
    d4_valid   = 1'b1;
    d4_sel     = 2'd0;
    tick();
    d4_sel = 2'd1;
    n_checks++;
    if (d4_out !== 32'hAAAA || d4_valid_o !== 1'b1 || d4_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_a: data=%h valid=%b ready=%b, want aaaa 1 1", d4_out, d4_valid_o, d4_ready_o);
    end
    tick();
    d4_sel = 2'd2;
    n_checks++;
    if (d4_out !== 32'hAAAA || d4_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_b_skid: data=%h ready=%b, want aaaa 0", d4_out, d4_ready_o);
    end
    tick();
    n_checks++;
    if (d4_out !== 32'hAAAA || d4_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_c_refused: data=%h ready=%b, want aaaa 0", d4_out, d4_ready_o);
    end
    d4_ready_i = 1'b1;
    tick();
    n_checks++;
    if (d4_out !== 32'hBBBB || d4_valid_o !== 1'b1 || d4_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_b_out: data=%h valid=%b ready=%b, want bbbb 1 1", d4_out, d4_valid_o, d4_ready_o);
    end
    tick();
    d4_valid = 1'b0;
    n_checks++;
    if (d4_out !== 32'hCCCC || d4_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_c_out: data=%h valid=%b, want cccc 1", d4_out, d4_valid_o);
    end
    tick();
    n_checks++;
    if (d4_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_empty: valid=%b, want 0", d4_valid_o);
    end
  endtask

  // 100 words with random valid gaps and random ready; scoreboard on order/values.
  task automatic test_back_to_back();
    int sent, got, cycles;
    logic [31:0] w [4];
    logic [31:0] exp_w;
    logic acc, drn;
    sent = 0; got = 0; cycles = 0;
    exp_q.delete();
    while (got < 100 && cycles < 3000) begin
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      d4_data    = {w[3], w[2], w[1], w[0]};
      d4_sel     = 2'($urandom_range(0, 3));
      d4_valid   = (sent < 100) && ($urandom_range(0, 3) != 0);
      d4_ready_i = ($urandom_range(0, 2) != 0);
      acc = d4_valid && d4_ready_o;
      drn = d4_valid_o && d4_ready_i;
      if (drn) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: got %h, want no word", d4_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (d4_out !== exp_w) begin
            n_fail++;
            $display("FAIL stream_word%0d: got %h, want %h", got, d4_out, exp_w);
          end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(w[d4_sel]);
        sent++;
      end
      tick();
      cycles++;
    end
    d4_valid   = 1'b0;
    d4_ready_i = 1'b1;
    n_checks++;
    if (got != 100 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: got %0d words, %0d pending, want 100 and 0", got, exp_q.size());
    end
    tick();
    tick();
  endtask

  // Async reset with both entries full, then a clean restart.
  task automatic test_reset_mid();
    d4_data    = {32'h4, 32'h3, 32'h2, 32'h1};
    d4_ready_i = 1'b0;
    d4_valid   = 1'b1;
    d4_sel     = 2'd0;
    tick();
    d4_sel = 2'd1;
    tick();
    d4_valid = 1'b0;
    n_checks++;
    if (d4_ready_o !== 1'b0 || d4_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_full: ready=%b valid=%b, want 0 1", d4_ready_o, d4_valid_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (d4_valid_o !== 1'b0 || d4_ready_o !== 1'b1 || d4_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%b ready=%b data=%h, want 0 1 0", d4_valid_o, d4_ready_o, d4_out);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    d4_ready_i = 1'b1;
    tick();
    n_checks++;
    if (d4_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_stale: valid=%b, want 0", d4_valid_o);
    end
    d4_valid = 1'b1;
    d4_sel   = 2'd3;
    tick();
    d4_valid = 1'b0;
    n_checks++;
    if (d4_valid_o !== 1'b1 || d4_out !== 32'h4) begin
      n_fail++;
      $display("FAIL rstmid_first: valid=%b data=%h, want 1 00000004", d4_valid_o, d4_out);
    end
    tick();
  endtask

  // Sweep all 16 selects on the 16x8 instance.
  task automatic test_sweep16();
    logic [7:0] v;
    for (int k = 0; k < 16; k++) d16_data[k*8 +: 8] = 8'(k * 13 + 5);
    d16_ready_i = 1'b1;
    d16_valid   = 1'b1;
    for (int k = 0; k < 16; k++) begin
      d16_sel = 4'(k);
      tick();
      v = 8'(k * 13 + 5);
      n_checks++;
      if (d16_out !== v || d16_valid_o !== 1'b1 || d16_err !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep16_sel%0d: data=%h valid=%b err=%b, want %h 1 0", k, d16_out, d16_valid_o, d16_err, v);
      end
    end
    d16_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_select();
    test_sel_err();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_sweep16();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
